// File: rtl/matvec_row_scheduler.sv
// matvec_row_scheduler: computes Y = W*X by time-sharing one dot-product engine across ROWS rows.
// Define MATVEC_SCHED_RELU_EN to clamp negative-sign row results to +0 on store.
module matvec_row_scheduler #(
    parameter int VLEN = 1,
    parameter int ROWS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [32*VLEN*ROWS-1:0] W,
    input  logic [32*VLEN-1:0]     X,
    output logic [32*VLEN-1:0]     eng_A,
    output logic [32*VLEN-1:0]     eng_B,
    input  logic                   eng_done,
    input  logic [31:0]            eng_result,
    output logic [32*ROWS-1:0]     Y,
    output logic                   busy,
    output logic                   done
);
    localparam int RW = $clog2(ROWS) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT, STORE, FIN} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [32*VLEN-1:0]    eng_a_q, eng_a_d, eng_b_q, eng_b_d;
    logic [32*ROWS-1:0]    y_q, y_d;
    logic [31:0]           res;

`ifdef MATVEC_SCHED_RELU_EN
    assign res = eng_result[31] ? 32'h0000_0000 : eng_result;
`else
    assign res = eng_result;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        eng_a_d = eng_a_q;
        eng_b_d = eng_b_q;
        y_d     = y_q;
        case (state_q)
            IDLE: if (start) begin
                row_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                eng_a_d = W[32*VLEN*int'(row_q) +: 32*VLEN];
                eng_b_d = X;
                state_d = ARM;
            end
            // engine done may still be high from the previous row here
            ARM:  state_d = WAIT;
            WAIT: if (eng_done) state_d = STORE;
            STORE: begin
                y_d[32*int'(row_q) +: 32] = res;
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = FIN;
                end else begin
                    row_d   = row_q + RW'(1);
                    state_d = LOAD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            eng_a_q <= '0;
            eng_b_q <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            eng_a_q <= eng_a_d;
            eng_b_q <= eng_b_d;
            y_q     <= y_d;
        end
    end

    assign eng_A = eng_a_q;
    assign eng_B = eng_b_q;
    assign Y     = y_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == FIN);
endmodule
